// File: rtl/systolic_pe.sv
// Binary-CNN systolic processing element: XNOR match of activation/weight added
// (saturating) to the upstream partial sum, with activation/weight forwarded.
module systolic_pe #(
  parameter int SUM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 in_bit,
  input  logic                 weight_bit,
  input  logic [SUM_WIDTH-1:0] partial_sum_in,
  output logic [SUM_WIDTH-1:0] partial_sum_out,
  output logic                 valid_out,
  output logic                 in_bit_out,
  output logic                 weight_bit_out
);

  localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 valid_q, valid_d;
  logic                 in_q, in_d;
  logic                 w_q, w_d;
  logic                 match;

  // Data registers only load on valid, so idle-cycle inputs never reach the outputs.
  always_comb begin
    match   = ~(in_bit ^ weight_bit);
    sum_d   = sum_q;
    in_d    = in_q;
    w_d     = w_q;
    valid_d = 1'b0;
    if (valid_in) begin
      valid_d = 1'b1;
      in_d    = in_bit;
      w_d     = weight_bit;
      if (match && (partial_sum_in != SUM_MAX))
        sum_d = partial_sum_in + SUM_WIDTH'(1);
      else
        sum_d = partial_sum_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      in_q    <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
      in_q    <= in_d;
      w_q     <= w_d;
    end
  end

  assign partial_sum_out = sum_q;
  assign valid_out       = valid_q;
  assign in_bit_out      = in_q;
  assign weight_bit_out  = w_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe at SUM_WIDTH 4 and 8 against a popcount reference model.
module tb_systolic_pe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       v4, a4, w4;
  logic [3:0] s4;
  logic [3:0] o_sum4;
  logic       o_v4, o_a4, o_w4;

  logic       v8, a8, w8;
  logic [7:0] s8;
  logic [7:0] o_sum8;
  logic       o_v8, o_a8, o_w8;

  int checks = 0;
  int errors = 0;

  // reference model state (what each PE should be presenting)
  int m4_sum, m8_sum;
  bit m4_v, m4_a, m4_w, m8_v;

  always #5 clk = ~clk;

  systolic_pe #(.SUM_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(v4), .in_bit(a4), .weight_bit(w4),
    .partial_sum_in(s4), .partial_sum_out(o_sum4), .valid_out(o_v4),
    .in_bit_out(o_a4), .weight_bit_out(o_w4));

  systolic_pe #(.SUM_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .valid_in(v8), .in_bit(a8), .weight_bit(w8),
    .partial_sum_in(s8), .partial_sum_out(o_sum8), .valid_out(o_v8),
    .in_bit_out(o_a8), .weight_bit_out(o_w8));

  // popcount step: add 1 when the bits agree, clamp at the all-ones value
  function automatic int ref_sum(input int s, input bit a, input bit w, input int width);
    int t;
    int mx;
    mx = (1 << width) - 1;
    t  = s + ((a == w) ? 1 : 0);
    return (t > mx) ? mx : t;
  endfunction

  task automatic model_clear();
    m4_sum = 0; m4_v = 0; m4_a = 0; m4_w = 0;
    m8_sum = 0; m8_v = 0;
  endtask

  task automatic drive4(input bit v, input bit a, input bit w, input int s);
    @(negedge clk);
    v4 = v; a4 = a; w4 = w; s4 = 4'(s);
    @(posedge clk); #1;
    if (v) begin
      m4_sum = ref_sum(s, a, w, 4); m4_a = a; m4_w = w; m4_v = 1;
    end else begin
      m4_v = 0;
    end
  endtask

  task automatic drive8(input bit v, input bit a, input bit w, input int s);
    @(negedge clk);
    v8 = v; a8 = a; w8 = w; s8 = 8'(s);
    @(posedge clk); #1;
    if (v) begin
      m8_sum = ref_sum(s, a, w, 8); m8_v = 1;
    end else begin
      m8_v = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    v4 = 1; a4 = 1; w4 = 1; s4 = 4'd7;
    v8 = 1; a8 = 0; w8 = 0; s8 = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_sum4, o_v4, o_a4, o_w4} !== 7'd0) begin
      errors++; $display("FAIL reset_held4 got %b exp 0", {o_sum4, o_v4, o_a4, o_w4});
    end
    checks++;
    if ({o_sum8, o_v8, o_a8, o_w8} !== 11'd0) begin
      errors++; $display("FAIL reset_held8 got %b exp 0", {o_sum8, o_v8, o_a8, o_w8});
    end
    @(negedge clk);
    v4 = 0; v8 = 0;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      drive4(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      checks++;
      if ({o_sum4, o_v4, o_a4, o_w4} !== 7'd0) begin
        errors++; $display("FAIL reset_release%0d got %b exp 0", i, {o_sum4, o_v4, o_a4, o_w4});
      end
    end
  endtask

  task automatic test_single_pulse();
    int ta[5] = '{1, 0, 1, 0, 1};
    int tw[5] = '{1, 1, 0, 0, 1};
    int ts[5] = '{0, 1, 1, 1, 2};
    int te[5] = '{1, 1, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      drive4(1, ta[i][0], tw[i][0], ts[i]);
      checks++;
      if (o_sum4 !== 4'(te[i]) || o_sum4 !== 4'(m4_sum) || o_v4 !== 1'b1) begin
        errors++; $display("FAIL pulse%0d sum %0d v %b exp sum %0d v 1", i, o_sum4, o_v4, te[i]);
      end
      checks++;
      if (o_a4 !== ta[i][0] || o_w4 !== tw[i][0]) begin
        errors++; $display("FAIL pulse_fwd%0d got %b%b exp %0d%0d", i, o_a4, o_w4, ta[i], tw[i]);
      end
      drive4(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      checks++;
      if (o_v4 !== 1'b0 || o_sum4 !== 4'(te[i]) || o_a4 !== ta[i][0] || o_w4 !== tw[i][0]) begin
        errors++; $display("FAIL idle_hold%0d sum %0d v %b exp sum %0d v 0", i, o_sum4, o_v4, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ta[4] = '{1, 0, 1, 0};
    int tw[4] = '{1, 0, 0, 1};
    int ts[4] = '{3, 7, 9, 0};
    int te[4] = '{4, 8, 9, 0};
    for (int i = 0; i < 4; i++) begin
      drive4(1, ta[i][0], tw[i][0], ts[i]);
      checks++;
      if (o_sum4 !== 4'(te[i]) || o_v4 !== 1'b1 || o_a4 !== ta[i][0] || o_w4 !== tw[i][0]) begin
        errors++;
        $display("FAIL b2b%0d sum %0d v %b fwd %b%b exp sum %0d v 1 fwd %0d%0d",
                 i, o_sum4, o_v4, o_a4, o_w4, te[i], ta[i], tw[i]);
      end
    end
    drive4(0, 0, 0, 0);
    checks++;
    if (o_v4 !== 1'b0) begin
      errors++; $display("FAIL b2b_end valid %b exp 0", o_v4);
    end
  endtask

  task automatic test_saturation();
    int ta[3] = '{1, 0, 1};
    int tw[3] = '{1, 1, 1};
    int ts[3] = '{15, 15, 14};
    for (int i = 0; i < 3; i++) begin
      drive4(1, ta[i][0], tw[i][0], ts[i]);
      checks++;
      if (o_sum4 !== 4'd15 || o_v4 !== 1'b1) begin
        errors++; $display("FAIL sat%0d sum %0d v %b exp sum 15 v 1", i, o_sum4, o_v4);
      end
    end
  endtask

  task automatic test_async_reset();
    drive4(1, 1, 1, 4);
    checks++;
    if (o_sum4 !== 4'd5 || o_v4 !== 1'b1) begin
      errors++; $display("FAIL arst_setup sum %0d v %b exp sum 5 v 1", o_sum4, o_v4);
    end
    // mid-cycle assertion, well before the next rising edge
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_sum4, o_v4, o_a4, o_w4} !== 7'd0) begin
      errors++; $display("FAIL arst_async got %b exp 0", {o_sum4, o_v4, o_a4, o_w4});
    end
    model_clear();
    @(negedge clk);
    v4 = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive4(0, 1, 1, 4);
      checks++;
      if (o_v4 !== 1'b0 || o_sum4 !== 4'd0) begin
        errors++; $display("FAIL arst_release%0d sum %0d v %b exp sum 0 v 0", i, o_sum4, o_v4);
      end
    end
  endtask

  task automatic test_width8();
    int ta[3] = '{1, 1, 0};
    int tw[3] = '{1, 1, 0};
    int ts[3] = '{254, 255, 100};
    int te[3] = '{255, 255, 101};
    for (int i = 0; i < 3; i++) begin
      drive8(1, ta[i][0], tw[i][0], ts[i]);
      checks++;
      if (o_sum8 !== 8'(te[i]) || o_v8 !== 1'b1 || o_a8 !== ta[i][0] || o_w8 !== tw[i][0]) begin
        errors++; $display("FAIL w8_%0d sum %0d v %b exp sum %0d v 1", i, o_sum8, o_v8, te[i]);
      end
    end
    drive8(0, 0, 1, 3);
    checks++;
    if (o_v8 !== 1'b0 || o_sum8 !== 8'd101) begin
      errors++; $display("FAIL w8_idle sum %0d v %b exp sum 101 v 0", o_sum8, o_v8);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive4(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      checks++;
      if (o_sum4 !== 4'(m4_sum) || o_v4 !== m4_v || o_a4 !== m4_a || o_w4 !== m4_w) begin
        errors++;
        $display("FAIL rand%0d sum %0d v %b fwd %b%b exp sum %0d v %b fwd %b%b",
                 i, o_sum4, o_v4, o_a4, o_w4, m4_sum, m4_v, m4_a, m4_w);
      end
    end
  endtask

  initial begin
    v4 = 0; a4 = 0; w4 = 0; s4 = '0;
    v8 = 0; a8 = 0; w8 = 0; s8 = '0;
    model_clear();
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_width8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Single processing element of the binary-CNN systolic popcount array. Each valid cycle it XNORs one activation bit with one weight bit and adds the result to the partial sum arriving from its upstream neighbour. It registers the updated sum with a valid flag for the downstream PE. It also forwards the activation and weight bits so a grid of identical PEs can be tiled without external fan-out.

## Interface
Parameters:
- SUM_WIDTH, 4, width of partial-sum input and output; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- valid_in  input  1  qualifies in_bit, weight_bit and partial_sum_in this cycle.
- in_bit  input  1  binary activation (1 = +1, 0 = −1).
- weight_bit  input  1  binary weight (same encoding).
- partial_sum_in  input  SUM_WIDTH  unsigned running popcount from the upstream PE.
- partial_sum_out  output  SUM_WIDTH  registered, updated popcount.
- valid_out  output  1  registered copy of valid_in.
- in_bit_out  output  1  registered activation, forwarded to the next PE along the row.
- weight_bit_out  output  1  registered weight, forwarded to the next PE along the column.

## Operation
- Match term: m = ~(in_bit ^ weight_bit), giving 1 when the bits are equal.
- On valid_in = 1, evaluated at the rising edge:
  - partial_sum_out ← partial_sum_in + m.
  - The addition is unsigned and saturating. If partial_sum_in = 2^SUM_WIDTH−1 and m = 1, the output stays at 2^SUM_WIDTH−1; it never wraps to 0.
  - in_bit_out ← in_bit; weight_bit_out ← weight_bit; valid_out ← 1.
- On valid_in = 0:
  - partial_sum_out, in_bit_out and weight_bit_out hold their previous values.
  - valid_out ← 0.
- Downstream logic must consume partial_sum_out only when valid_out = 1.
- The PE does not accumulate internally. Accumulation happens only through the partial_sum_in chain, so each output depends only on the inputs of the single preceding valid cycle.
- There is no backpressure. Every valid input produces exactly one valid output one cycle later.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency is 1 cycle. Inputs sampled at edge N appear at the outputs after edge N and remain stable until edge N+1.
- Throughput is one operation per cycle. Back-to-back valid_in pulses are fully supported.
- Reset (reset = 0) acts asynchronously:
  - partial_sum_out = 0, valid_out = 0, in_bit_out = 0, weight_bit_out = 0, immediately and without waiting for a clock edge.
  - Outputs stay at these values while reset is held low.
- Reset deassertion: the first edge with reset = 1 samples the inputs normally. Any valid_in present at that edge is processed.
- Reset mid-operation: an in-flight result is discarded and valid_out drops to 0 at once. No stale valid is emitted after release.
- X or undefined data inputs while valid_in = 0 must not affect any output.

## Test plan
- Reset: hold reset = 0 with arbitrary inputs -> all outputs 0. Release, keep valid_in = 0 for 2 cycles -> outputs remain 0.
- Single-pulse sequence, SUM_WIDTH = 4, one-cycle valid pulses separated by one idle cycle:
  - (in, w, sum_in) = (1,1,0) -> out 1.
  - (0,1,1) -> out 1.
  - (1,0,1) -> out 1.
  - (0,0,1) -> out 2.
  - (1,1,2) -> out 3.
  - valid_out is high exactly one cycle per pulse; the sum holds during idle cycles.
- Back-to-back stream: valid_in high for 4 consecutive cycles with (1,1,3), (0,0,7), (1,0,9), (0,1,0) -> outputs 4, 8, 9, 0 on consecutive cycles. valid_out is high for 4 cycles. in_bit_out/weight_bit_out follow 1/1, 0/0, 1/0, 0/1.
- Saturation, SUM_WIDTH = 4:
  - (1,1,15) -> out 15, not 0.
  - (0,1,15) -> out 15.
  - (1,1,14) -> out 15.
- Async reset mid-stream: assert reset = 0 between clock edges while valid_out = 1 and the sum is 5 -> all outputs go to 0 before the next edge. After release with valid_in = 0, no valid_out appears.
- Parameter sweep: SUM_WIDTH = 8 with (1,1,254) -> 255, then (1,1,255) -> 255, then (0,0,100) -> 101.
